// File: rtl/p_layer_inv_pkg.sv
// ============================================================================
// Module      : p_layer_inv_pkg
// Description : Shared constants and FSM encodings for the inverse pLayer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package p_layer_inv_pkg;

    localparam int c_STATE_W = 264;
    localparam int c_NIB_CNT = c_STATE_W / 4;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/p_layer_inv_lane.sv
// ============================================================================
// Module      : p_layer_inv_lane
// Description : W-bit parallel-load, right-shift lane; LSB feeds one nibble bit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module p_layer_inv_lane #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_din,
    output logic         o_lsb
);

    logic [W-1:0] r_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_din;
        end else if (i_shift) begin
            r_sh <= {1'b0, r_sh[W-1:1]};
        end
    end

    assign o_lsb = r_sh[0];

endmodule

`default_nettype wire

// File: rtl/p_layer_inv.sv
// ============================================================================
// Module      : p_layer_inv
// Description : Serial inverse Spongent pLayer, one output nibble per cycle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module p_layer_inv
    import p_layer_inv_pkg::*;
#(
    parameter int B = c_STATE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [B-1:0] state_in,
    output logic [B-1:0] state_out,
    output logic         out_rdy
);

    localparam int D  = B / 4;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [B-1:0]  r_out;
    logic          r_rdy;
    logic [3:0]    w_nib;
    logic          w_load;
    logic          w_shift;

    assign w_load  = (r_state == c_ST_IDLE) && en;
    assign w_shift = (r_state == c_ST_BUSY) && en;

    // Lane k holds input bits k*D .. k*D+D-1; its LSB is bit k of the current nibble.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        p_layer_inv_lane #(
            .W (D)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_din   (state_in[k*D +: D]),
            .o_lsb   (w_nib[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (en) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (en) begin
                        // Nibbles enter at the top, so after D shifts nibble c lands at 4c.
                        r_out <= {w_nib, r_out[B-1:4]};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(D - 1)) begin
                            r_state <= c_ST_DONE;
                            r_rdy   <= 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (!en) begin
                        r_state <= c_ST_IDLE;
                        r_rdy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign state_out = r_out;
    assign out_rdy   = r_rdy;

endmodule

`default_nettype wire

// File: tb/tb_p_layer_inv.sv
// ============================================================================
// Module      : tb_p_layer_inv
// Description : Scoreboard bench for p_layer_inv at B=264 with directed vectors.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_p_layer_inv;

    localparam int c_B = 264;

    typedef struct {
        logic [c_B-1:0] val;
        bit             rt;
        string          nm;
    } sb_entry_t;

    logic           clk;
    logic           rst;
    logic           en;
    logic [c_B-1:0] state_in;
    logic [c_B-1:0] state_out;
    logic           out_rdy;

    int        checks;
    int        errors;
    sb_entry_t sb_q[$];
    logic      prev_rdy;

    p_layer_inv #(
        .B (c_B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .state_in  (state_in),
        .state_out (state_out),
        .out_rdy   (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward Spongent pLayer: bit j moves to j*66 mod 263, top bit fixed.
    function automatic logic [c_B-1:0] fwd_player(input logic [c_B-1:0] x);
        logic [c_B-1:0] y;
        y = '0;
        for (int j = 0; j < c_B - 1; j++) y[(j * (c_B / 4)) % (c_B - 1)] = x[j];
        y[c_B-1] = x[c_B-1];
        return y;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [c_B-1:0] act,
                       input logic [c_B-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: pop one expectation on each rising out_rdy.
    always @(negedge clk) begin
        if (out_rdy && !prev_rdy) begin
            if (sb_q.size() == 0) begin
                chk(1'b0, "sb_unexpected_result", state_out, '0);
            end else begin
                sb_entry_t e;
                logic [c_B-1:0] got;
                e   = sb_q.pop_front();
                got = e.rt ? fwd_player(state_out) : state_out;
                chk(got == e.val, e.nm, got, e.val);
            end
        end
        prev_rdy = out_rdy;
    end

    task automatic run_op(input logic [c_B-1:0] d, input logic [c_B-1:0] e, input bit rt,
                          input string nm, input int stall_at, input int exp_edges,
                          input int hold);
        int n;
        bit done;
        bit stable;
        logic [c_B-1:0] snap;
        sb_q.push_back('{val: e, rt: rt, nm: nm});
        state_in = d;
        en       = 1'b1;
        n        = 0;
        done     = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) state_in = ~d;
            if (out_rdy) begin
                done = 1'b1;
            end else if (stall_at > 0) begin
                if (n == stall_at + 1)  en = 1'b0;
                if (n == stall_at + 11) en = 1'b1;
            end
        end
        chk(done && n == exp_edges, {nm, "_latency"}, c_B'(n), c_B'(exp_edges));
        if (hold > 0) begin
            snap   = state_out;
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (state_out != snap || !out_rdy) stable = 1'b0;
            end
            chk(stable, {nm, "_hold_stable"}, state_out, snap);
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        chk(out_rdy == 1'b0, {nm, "_rdy_clear"}, c_B'(out_rdy), '0);
    endtask

    localparam logic [c_B-1:0] c_ONE = 264'd1;
    localparam logic [c_B-1:0] c_RT1 =
        264'h20d6d3dcd9d5d8dad7dfd4d1d2d0dbdddee6e3ece9e5e8eae7efe4e1e2e0ebed94;
    localparam logic [c_B-1:0] c_RT2 =
        264'ha8365886353658867333568863335688ca2ed1e22f3856833e55353353dd2d22a5;

    initial begin
        checks   = 0;
        errors   = 0;
        prev_rdy = 1'b0;
        rst      = 1'b1;
        en       = 1'b0;
        state_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(out_rdy == 1'b0, "reset_rdy", c_B'(out_rdy), '0);
        chk(state_out == '0, "reset_out", state_out, '0);
        @(negedge clk);
        rst = 1'b0;

        run_op(c_ONE << 1,   c_ONE << 4,   1'b0, "t1_bit1",   0, 67, 0);
        run_op(c_ONE << 66,  c_ONE << 1,   1'b0, "t2_bit66",  0, 67, 0);
        run_op(c_ONE << 65,  c_ONE << 260, 1'b0, "t2_bit65",  0, 67, 0);
        run_op(c_ONE << 263, c_ONE << 263, 1'b0, "t2_bit263", 0, 67, 0);
        run_op(c_ONE,        c_ONE,        1'b0, "t2_bit0",   0, 67, 0);
        run_op(c_ONE << 132, c_ONE << 2,   1'b0, "t2_bit132", 0, 67, 0);
        run_op({c_B{1'b1}},  {c_B{1'b1}},  1'b0, "t2_ones",   0, 67, 0);
        run_op('0,           '0,           1'b0, "t2_zero",   0, 67, 0);
        run_op(c_RT1,        c_RT1,        1'b1, "t3_rt1",    0, 67, 0);
        run_op(c_RT2,        c_RT2,        1'b1, "t3_rt2",    0, 67, 0);
        run_op(c_ONE << 1,   c_ONE << 4,   1'b0, "t4_stall",  30, 77, 0);

        // Abort a run after 40 shifts; reset must clear outputs without a clock edge.
        state_in = c_ONE << 1;
        en       = 1'b1;
        repeat (41) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(out_rdy == 1'b0, "t5_rst_rdy", c_B'(out_rdy), '0);
        chk(state_out == '0, "t5_rst_out", state_out, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(c_ONE << 1,   c_ONE << 4,   1'b0, "t5_rerun",  0, 67, 0);

        run_op(c_ONE << 65,  c_ONE << 260, 1'b0, "t6_hold",   0, 67, 20);
        run_op(c_ONE << 200, c_ONE << 11,  1'b0, "t6_restart", 0, 67, 0);

        repeat (2) @(posedge clk);
        #1;
        chk(sb_q.size() == 0, "sb_drained", c_B'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
